// File: rtl/nn_pkg.sv
// nn_pkg: shared word type, lane count, magnitude limit and collector states for the neuron datapath
package nn_pkg;
  localparam int N = 16;
  localparam int F = 8;
  localparam int LANES = 7;
  localparam logic [N-2:0] MAG_MAX = '1;
  typedef logic [N-1:0] sm_word_t;
  typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/sm_mult.sv
// sm_mult: combinational signed-magnitude fixed-point multiply with truncate, saturate and zero-normalise
module sm_mult #(
  parameter int N = nn_pkg::N,
  parameter int F = nn_pkg::F
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p,
  output logic         sat
);
  logic [2*N-3:0] w_full;
  logic [2*N-3:0] w_shr;
  logic [N-2:0]   w_mag;
  always_comb begin
    w_full = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
    w_shr  = w_full >> F;
    sat    = w_shr > {{(N-1){1'b0}}, {(N-1){1'b1}}};
    w_mag  = sat ? '1 : w_shr[N-2:0];
    p      = (w_mag == '0) ? '0 : {a[N-1] ^ b[N-1], w_mag};
  end
endmodule

// File: rtl/product_collect7.sv
// product_collect7: multiplies accepted pairs and collects seven products into a held output vector
module product_collect7
  import nn_pkg::*;
#(
  parameter int N = nn_pkg::N,
  parameter int F = nn_pkg::F,
  parameter int LANES = nn_pkg::LANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_p [LANES],
  output logic         out_sat
);
  localparam int CW = $clog2(LANES);
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_sat, w_sat_nxt;
  logic [N-1:0]    r_lanes [LANES];
  logic [N-1:0]    w_p;
  logic            w_psat, w_acc, w_drain, w_last;
  sm_mult #(.N(N), .F(F)) u_mult (.a(in_x), .b(in_w), .p(w_p), .sat(w_psat));
  always_comb begin
    in_ready    = r_state == FILL;
    out_valid   = r_state == FULL;
    w_acc       = in_valid && in_ready;
    w_drain     = out_valid && out_ready;
    w_last      = r_cnt == CW'(LANES - 1);
    w_state_nxt = flush ? FILL : (w_acc && w_last) ? FULL : w_drain ? FILL : r_state;
    w_cnt_nxt   = (flush || (w_acc && w_last)) ? '0 : w_acc ? r_cnt + 1'b1 : r_cnt;
    w_sat_nxt   = (flush || w_drain) ? 1'b0 : (w_acc && w_psat) ? 1'b1 : r_sat;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_lanes[i] <= '0;
      else if (w_acc && !flush && r_cnt == CW'(i)) r_lanes[i] <= w_p;
    end
  end
  assign out_p   = r_lanes;
  assign out_sat = r_sat;
endmodule

// File: tb/tb_product_collect7.sv
// tb_product_collect7: directed vectors with a queue scoreboard checked by a drain monitor
module tb_product_collect7;
  typedef logic [6:0][15:0] pvec_t;
  typedef struct packed {pvec_t p; logic sat;} exp_t;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] in_x = 0, in_w = 0;
  logic [15:0] out_p [7];
  int          tests = 0, fails = 0;
  exp_t        q[$];
  product_collect7 #(.N(16), .F(8), .LANES(7)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  function automatic pvec_t pk();
    pvec_t r;
    for (int i = 0; i < 7; i++) r[i] = out_p[i];
    return r;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_vector", 128'(pk()), 128'(0));
      else begin
        e = q.pop_front();
        chk("vector", 128'({pk(), out_sat}), 128'(e));
      end
    end
  end
  task automatic send(input logic [15:0] x, input logic [15:0] w);
    int t = 0;
    in_valid = 1; in_x = x; in_w = w;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("send_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic send_vec(input pvec_t xs, input pvec_t ws, input int n);
    for (int i = 0; i < n; i++) send(xs[i], ws[i]);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    pvec_t xs, ws, ex;
    #12;
    chk("reset_state", {out_valid, in_ready, out_sat, pk()}, {3'b010, 112'h0});
    rst_n = 1;
    @(posedge clk); #1;
    q.push_back({{7{16'h8300}}, 1'b0});
    send_vec({7{16'h0180}}, {7{16'h8200}}, 7);
    chk("basic_valid_on", out_valid, 1);
    chk("basic_ready_off", in_ready, 0);
    @(posedge clk); #1;
    chk("basic_valid_one_cycle", out_valid, 0);
    xs = {7{16'h0100}}; ws = {7{16'h0100}}; ex = {7{16'h0100}};
    xs[3] = 16'h7F00; ws[3] = 16'h0200; ex[3] = 16'h7FFF;
    q.push_back({ex, 1'b1});
    send_vec(xs, ws, 7);
    q.push_back({{7{16'h8300}}, 1'b0});
    send_vec({7{16'h0180}}, {7{16'h8200}}, 7);
    for (int i = 0; i < 7; i++) begin
      xs[i] = (i % 3 == 0) ? 16'h8000 : (i % 3 == 1) ? 16'h0001 : 16'h0100;
      ws[i] = (i % 3 == 0) ? 16'h0100 : (i % 3 == 1) ? 16'h8001 : 16'h8100;
      ex[i] = (i % 3 == 2) ? 16'h8100 : 16'h0000;
    end
    q.push_back({ex, 1'b0});
    send_vec(xs, ws, 7);
    @(posedge clk); #1;
    out_ready = 0;
    q.push_back({{7{16'h0600}}, 1'b0});
    send_vec({7{16'h0200}}, {7{16'h0300}}, 7);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_x = 16'(c * 16'h1357 + 16'h0F00); in_w = ~in_x;
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, out_sat, pk()}, {3'b100, {7{16'h0600}}});
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("bp_drained", {out_valid, in_ready}, 2'b01);
    send_vec({7{16'h0300}}, {7{16'h0300}}, 4);
    flush = 1; in_valid = 1; in_x = 16'h0500; in_w = 16'h0500;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_state", {out_valid, in_ready}, 2'b01);
    for (int i = 0; i < 7; i++) begin
      xs[i] = 16'((i + 1) * 256); ws[i] = 16'h0100; ex[i] = 16'((i + 1) * 256);
    end
    q.push_back({ex, 1'b0});
    send_vec(xs, ws, 7);
    @(posedge clk); #1;
    xs = {7{16'h0100}}; ws = {7{16'h0100}};
    xs[1] = 16'h7F00; ws[1] = 16'h0200;
    send_vec(xs, ws, 3);
    #3 rst_n = 0;
    #1 chk("async_reset", {out_valid, in_ready, out_sat, pk()}, {3'b010, 112'h0});
    #2 rst_n = 1;
    @(posedge clk); #1;
    q.push_back({{7{16'h8300}}, 1'b0});
    send_vec({7{16'h0180}}, {7{16'h8200}}, 7);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
